mod_inv: RTL and testbench

MOD_INV -- requirements
Module: mod_inv

---
 rtl/mod_inv_if.sv | 22 ++
 rtl/mod_inv.sv | 124 ++++++++++++
 tb/tb_mod_inv.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mod_inv_if.sv
// mod_inv_if: the request/response bundle for the modular inverter.
//   start  master->slave  request pulse, sampled only while the block is idle
//   a      master->slave  operand to invert, sampled with start
//   p      master->slave  modulus, sampled with start
//   busy   slave->master  high while iterating
//   done   slave->master  one-cycle completion pulse
//   c      slave->master  result a^-1 mod p, valid from done until the next accepted start
//   err    slave->master  no inverse / invalid operands, same lifetime as c
interface mod_inv_if #(
    parameter int LEN = 8
);
    logic           start;
    logic [LEN-1:0] a;
    logic [LEN-1:0] p;
    logic           busy;
    logic           done;
    logic [LEN-1:0] c;
    logic           err;

    modport master (output start, a, p, input  busy, done, c, err);
    modport slave  (input  start, a, p, output busy, done, c, err);
endinterface

// File: rtl/mod_inv.sv
// mod_inv: modular inverse c = a^-1 mod p by the binary extended Euclidean
// algorithm, one reduction step per clock.
//   clk  rising-edge clock
//   rst  synchronous active-high reset; aborts any calculation without a done pulse
//   bus  mod_inv_if.slave: start/a/p in, busy/done/c/err out
// Invariants while iterating: x1*a == u (mod p), x2*a == v (mod p), x1,x2 in [0,p-1].
module mod_inv #(
    parameter int LEN = 8
) (
    input  logic      clk,
    input  logic      rst,
    mod_inv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state, state_n;
    logic [LEN-1:0] u, u_n, v, v_n;
    logic [LEN-1:0] x1, x1_n, x2, x2_n;
    logic [LEN-1:0] p_r, p_n;
    logic           bad, bad_n;
    logic [LEN-1:0] c_r, c_n;
    logic           err_r, err_n;

    // x/2 mod p for odd p: odd x becomes (x+p)/2, summed one bit wider so the
    // carry survives when p is close to 2^LEN-1.
    function automatic logic [LEN-1:0] halve(input logic [LEN-1:0] x, input logic [LEN-1:0] m);
        logic [LEN:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
        return LEN'(s >> 1);
    endfunction

    // (x-y) mod m for x,y in [0,m-1]. When x<y, m-y is positive and
    // x+(m-y) < m, so the sum never exceeds LEN bits.
    function automatic logic [LEN-1:0] sub_mod(input logic [LEN-1:0] x, input logic [LEN-1:0] y,
                                               input logic [LEN-1:0] m);
        return (x >= y) ? (x - y) : (x + (m - y));
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            u     <= '0;
            v     <= '0;
            x1    <= '0;
            x2    <= '0;
            p_r   <= '0;
            bad   <= 1'b0;
            c_r   <= '0;
            err_r <= 1'b0;
        end else begin
            state <= state_n;
            u     <= u_n;
            v     <= v_n;
            x1    <= x1_n;
            x2    <= x2_n;
            p_r   <= p_n;
            bad   <= bad_n;
            c_r   <= c_n;
            err_r <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        u_n     = u;
        v_n     = v;
        x1_n    = x1;
        x2_n    = x2;
        p_n     = p_r;
        bad_n   = bad;
        c_n     = c_r;
        err_n   = err_r;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = CALC;
                    u_n     = bus.a;
                    v_n     = bus.p;
                    x1_n    = LEN'(1);
                    x2_n    = '0;
                    p_n     = bus.p;
                    // Operand check is latched here and acted on in the first
                    // CALC cycle, so bad requests cost exactly one CALC cycle.
                    bad_n   = (bus.a == '0) || (bus.a >= bus.p) || !bus.p[0] || (bus.p < LEN'(3));
                end
            end
            CALC: begin
                if (bad) begin
                    state_n = DONE;
                    c_n     = '0;
                    err_n   = 1'b1;
                end else if (u == LEN'(1) || v == LEN'(1)) begin
                    state_n = DONE;
                    c_n     = (u == LEN'(1)) ? x1 : x2;
                    err_n   = 1'b0;
                end else if (u == '0 || v == '0) begin
                    // gcd(a,p) > 1: no inverse exists
                    state_n = DONE;
                    c_n     = '0;
                    err_n   = 1'b1;
                end else if (!u[0]) begin
                    u_n  = u >> 1;
                    x1_n = halve(x1, p_r);
                end else if (!v[0]) begin
                    v_n  = v >> 1;
                    x2_n = halve(x2, p_r);
                end else if (u >= v) begin
                    u_n  = u - v;
                    x1_n = sub_mod(x1, x2, p_r);
                end else begin
                    v_n  = v - u;
                    x2_n = sub_mod(x2, x1, p_r);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.busy = (state == CALC);
    assign bus.done = (state == DONE);
    assign bus.c    = c_r;
    assign bus.err  = err_r;
endmodule

// File: tb/tb_mod_inv.sv
// tb_mod_inv: randomized and directed checks of mod_inv (LEN=8) against a
// brute-force modular-inverse model. The driver pushes expectations into a
// queue; a monitor pops and compares on every done pulse.
module tb_mod_inv;
    localparam int LEN = 8;
    localparam int MAX_LAT = 4 * LEN + 2;

    typedef struct {
        logic [LEN-1:0] c;
        logic           err;
        int             lat;     // exact CALC-cycle count expected, or -1 for bound only
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    mod_inv_if #(.LEN(LEN)) bus ();
    mod_inv #(.LEN(LEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endfunction

    // Reference: validity rules, then search for the inverse directly.
    function automatic exp_t model(int a, int p);
        exp_t e;
        e.c = '0; e.err = 1'b1; e.lat = -1;
        if (a == 0 || a >= p || (p % 2) == 0 || p < 3) begin
            e.lat = 1;
            return e;
        end
        if (a == 1) e.lat = 1;
        for (int k = 1; k < p; k++)
            if ((a * k) % p == 1) begin
                e.c = LEN'(k); e.err = 1'b0;
                return e;
            end
        return e;
    endfunction

    // Monitor: counts CALC cycles, checks each done against the queue.
    int   busy_cnt = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (bus.done) begin
            chk("done_one_cycle", int'(prev_done), 0);
            chk("busy_low_in_done", int'(bus.busy), 0);
            chk("done_expected", (q.size() > 0) ? 1 : 0, 1);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("c", int'(bus.c), int'(e.c));
                chk("err", int'(bus.err), int'(e.err));
                if (e.lat >= 0) chk("latency_exact", busy_cnt, e.lat);
                else            chk("latency_bound", (busy_cnt <= MAX_LAT) ? 1 : 0, 1);
            end
            busy_cnt = 0;
        end else if (bus.busy) begin
            busy_cnt++;
        end else begin
            busy_cnt = 0;
        end
        prev_done = bus.done;
    end

    task automatic issue(input int a, input int p, input bit push);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = LEN'(a);
        bus.p     = LEN'(p);
        if (push) q.push_back(model(a, p));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Returns at the negedge where done is seen (monitor has already checked it).
    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            errors++; checks++;
            $display("FAIL timeout: no done after %0d cycles", n);
        end
    endtask

    task automatic run(input int a, input int p);
        issue(a, p, 1'b1);
        wait_done();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.p     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_c", int'(bus.c), 0);
        chk("rst_err", int'(bus.err), 0);
        rst = 1'b0;

        // Accept on the first cycle after reset; result held afterwards.
        run(78, 113);
        repeat (3) @(negedge clk);
        chk("hold_c", int'(bus.c), 71);
        chk("hold_err", int'(bus.err), 0);

        // Back-to-back: next start in the IDLE cycle right after done.
        run(28, 47);
        run(3, 7);
        run(1, 113);
        run(112, 113);
        run(6, 9);
        run(0, 7);
        run(5, 8);
        run(120, 113);
        run(1, 2);

        // Start pulsed mid-CALC must be ignored.
        issue(78, 113, 1'b1);
        repeat (3) @(negedge clk);
        chk("busy_mid_calc", int'(bus.busy), 1);
        issue(2, 113, 1'b0);
        wait_done();
        repeat (2) @(negedge clk);
        chk("no_restart", int'(bus.busy), 0);

        // Reset mid-CALC: no done, outputs cleared, then normal operation.
        issue(78, 113, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_c", int'(bus.c), 0);
        chk("abort_err", int'(bus.err), 0);
        repeat (3) @(negedge clk);
        run(3, 7);

        // Random operands and moduli.
        for (int i = 0; i < 60; i++) begin
            int p;
            p = int'($urandom_range(0, 255));
            run(int'($urandom_range(0, 255)) % (p + 2), p);
        end

        // Sweep every operand for the prime 251.
        for (int a = 1; a <= 250; a++) run(a, 251);

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
